// File: rtl/nou_pkg.sv
// Shared NoC response types: entry layout, payload bit offsets and the output FSM states.
// Default field widths for transaction id, tile id, error code and NoC response payload.
package nou_pkg;

    localparam int NOU_TID_W  = 8;
    localparam int NOU_TILE_W = 10;
    localparam int NOU_ERR_W  = 5;
    localparam int NOU_RSP_W  = 32;

    localparam int RSP_TILE_LSB   = 0;
    localparam int RSP_STATUS_BIT = 10;
    localparam int RSP_ERR_LSB    = 11;

    typedef struct packed {
        logic [NOU_TID_W-1:0]  tid;
        logic [NOU_TILE_W-1:0] tile_id;
        logic                  status;
        logic [NOU_ERR_W-1:0]  err_code;
    } nou_rsp_entry_t;

    typedef enum logic {
        OBR_IDLE = 1'b0,
        OBR_SEND = 1'b1
    } obr_state_e;

    // An OK response carries no error code, whatever the engine left on the bus.
    function automatic logic [15:0] nou_pack_rsp(input logic [NOU_TILE_W-1:0] tile_id,
                                                 input logic                  status,
                                                 input logic [NOU_ERR_W-1:0]  err_code);
        logic [15:0] r;
        r = '0;
        r[RSP_TILE_LSB +: NOU_TILE_W] = tile_id;
        r[RSP_STATUS_BIT]             = status;
        r[RSP_ERR_LSB +: NOU_ERR_W]   = status ? err_code : '0;
        return r;
    endfunction

endpackage

// File: rtl/spu_obr_fifo.sv
// Sync FIFO of completion entries with reset storage; extra pointer MSB separates full from empty.
// Latency: a push is visible at the head the next cycle. Backpressure: push ignored when full, pop ignored when empty.
module spu_obr_fifo
    import nou_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           push,
    input  nou_rsp_entry_t push_dat,
    input  logic           pop,
    output nou_rsp_entry_t pop_dat,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    nou_rsp_entry_t mem_q [DEPTH];
    nou_rsp_entry_t mem_d [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/spu_obr_gen.sv
// SPU outbound response generator: queues completions, packs them, drives them to the NoC.
// Latency: 2 cycles from push to ob_rsp_vld when idle. Backpressure: cmpl_rdy = !fifo_full; output held until ob_rsp_rdy.
// SPU_OBR_ERR_CNT_EN adds a saturating count of sent error responses (err_cnt / err_cnt_clr).
module spu_obr_gen
    import nou_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TID_W  = NOU_TID_W,
    parameter int TILE_W = NOU_TILE_W,
    parameter int ERR_W  = NOU_ERR_W,
    parameter int RSP_W  = NOU_RSP_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmpl_vld,
    output logic              cmpl_rdy,
    input  logic [TID_W-1:0]  cmpl_tid,
    input  logic [TILE_W-1:0] cmpl_tile_id,
    input  logic              cmpl_status,
    input  logic [ERR_W-1:0]  cmpl_err_code,
    output logic              ob_rsp_vld,
    input  logic              ob_rsp_rdy,
    output logic [TID_W-1:0]  ob_rsp_tid,
    output logic [RSP_W-1:0]  ob_rsp
`ifdef SPU_OBR_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt,
    input  logic              err_cnt_clr
`endif
);
    obr_state_e     state_q, state_d;
    logic [TID_W-1:0] tid_q, tid_d;
    logic [RSP_W-1:0] rsp_q, rsp_d;
    nou_rsp_entry_t push_dat, head;
    logic           fifo_full, fifo_empty, fifo_pop;

    assign push_dat.tid      = cmpl_tid;
    assign push_dat.tile_id  = cmpl_tile_id;
    assign push_dat.status   = cmpl_status;
    assign push_dat.err_code = cmpl_err_code;
    assign cmpl_rdy          = !fifo_full;

    spu_obr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (cmpl_vld),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Output register reloads on the accepting cycle so a busy queue drains one response per cycle.
    always_comb begin
        state_d  = state_q;
        tid_d    = tid_q;
        rsp_d    = rsp_q;
        fifo_pop = 1'b0;
        case (state_q)
            OBR_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = OBR_SEND;
                end
            end
            OBR_SEND: begin
                if (ob_rsp_rdy) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = OBR_IDLE;
                    end
                end
            end
        endcase
        if (fifo_pop) begin
            tid_d        = head.tid;
            rsp_d        = '0;
            rsp_d[15:0]  = nou_pack_rsp(head.tile_id, head.status, head.err_code);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= OBR_IDLE;
            tid_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
            rsp_q   <= rsp_d;
        end
    end

    assign ob_rsp_vld = (state_q == OBR_SEND);
    assign ob_rsp_tid = tid_q;
    assign ob_rsp     = rsp_q;

`ifdef SPU_OBR_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_hs;

    assign err_hs = ob_rsp_vld && ob_rsp_rdy && rsp_q[RSP_STATUS_BIT];

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (err_hs && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spu_obr_gen.sv
// Scoreboard bench for spu_obr_gen: stimulus queues expected responses, a negedge monitor checks them.
module tb_spu_obr_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmpl_vld;
    logic        cmpl_rdy;
    logic [7:0]  cmpl_tid;
    logic [9:0]  cmpl_tile_id;
    logic        cmpl_status;
    logic [4:0]  cmpl_err_code;
    logic        ob_rsp_vld;
    logic        ob_rsp_rdy;
    logic [7:0]  ob_rsp_tid;
    logic [31:0] ob_rsp;
`ifdef SPU_OBR_ERR_CNT_EN
    logic [15:0] err_cnt;
    logic        err_cnt_clr;
`endif

    typedef struct {
        logic [7:0]  tid;
        logic [31:0] rsp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic done;

    spu_obr_gen dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmpl_vld      (cmpl_vld),
        .cmpl_rdy      (cmpl_rdy),
        .cmpl_tid      (cmpl_tid),
        .cmpl_tile_id  (cmpl_tile_id),
        .cmpl_status   (cmpl_status),
        .cmpl_err_code (cmpl_err_code),
        .ob_rsp_vld    (ob_rsp_vld),
        .ob_rsp_rdy    (ob_rsp_rdy),
        .ob_rsp_tid    (ob_rsp_tid),
        .ob_rsp        (ob_rsp)
`ifdef SPU_OBR_ERR_CNT_EN
        ,
        .err_cnt       (err_cnt),
        .err_cnt_clr   (err_cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each accepted response with the scoreboard head and checks hold-while-stalled.
    logic        pend = 1'b0;
    logic [7:0]  last_tid;
    logic [31:0] last_rsp;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("no_retract", {31'd0, ob_rsp_vld}, 32'd1);
                chk("hold_tid", {24'd0, ob_rsp_tid}, {24'd0, last_tid});
                chk("hold_rsp", ob_rsp, last_rsp);
            end
            if (ob_rsp_vld && ob_rsp_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp tid=%h rsp=%h expected=none", ob_rsp_tid, ob_rsp);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_tid", {24'd0, ob_rsp_tid}, {24'd0, e.tid});
                    chk("rsp_payload", ob_rsp, e.rsp);
                end
            end
            pend     = ob_rsp_vld && !ob_rsp_rdy;
            last_tid = ob_rsp_tid;
            last_rsp = ob_rsp;
        end
    end

    task automatic push(input logic [7:0] tid, input logic [9:0] tile, input logic st,
                        input logic [4:0] err, input logic [15:0] exp16);
        logic ok;
        ok            = 1'b0;
        cmpl_vld      = 1'b1;
        cmpl_tid      = tid;
        cmpl_tile_id  = tile;
        cmpl_status   = st;
        cmpl_err_code = err;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (cmpl_rdy) begin
                ok = 1'b1;
                sb.push_back('{tid, {16'h0000, exp16}});
            end
            @(posedge clk);
            #1;
        end
        cmpl_vld = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 500 && sb.size() != 0; c++) @(negedge clk);
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e16;
        logic        st;
        rstn          = 1'b0;
        cmpl_vld      = 1'b0;
        cmpl_tid      = '0;
        cmpl_tile_id  = '0;
        cmpl_status   = 1'b0;
        cmpl_err_code = '0;
        ob_rsp_rdy    = 1'b1;
        done          = 1'b0;
`ifdef SPU_OBR_ERR_CNT_EN
        err_cnt_clr   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_cmpl_rdy", {31'd0, cmpl_rdy}, 32'd1);
        chk("rst_vld", {31'd0, ob_rsp_vld}, 32'd0);
        chk("rst_tid", {24'd0, ob_rsp_tid}, 32'd0);
        chk("rst_rsp", ob_rsp, 32'd0);
`ifdef SPU_OBR_ERR_CNT_EN
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_vld", {31'd0, ob_rsp_vld}, 32'd0);
        @(posedge clk); #1;

        // Single response: two-cycle latency, one-cycle pulse.
        push(8'd3, 10'h2A5, 1'b0, 5'd0, 16'h02A5);
        @(negedge clk); chk("lat_n1_vld", {31'd0, ob_rsp_vld}, 32'd0);
        @(negedge clk); chk("lat_n2_vld", {31'd0, ob_rsp_vld}, 32'd1);
        @(negedge clk); chk("pulse_vld", {31'd0, ob_rsp_vld}, 32'd0);
        @(posedge clk); #1;

        // Error packing and forced-zero error code on OK status.
        push(8'd7, 10'h001, 1'b1, 5'h13, 16'h9C01);
        push(8'd8, 10'h155, 1'b0, 5'h1F, 16'h0155);
        drain();
        @(posedge clk); #1;

        // Backpressure: fill register + FIFO, then release for back-to-back drain.
        ob_rsp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(i), 10'(10'h100 + i), 1'b0, 5'h0A, 16'(16'h0100 + i));
        @(negedge clk); chk("bp_rdy_after4", {31'd0, cmpl_rdy}, 32'd1);
        @(posedge clk); #1;
        push(8'd4, 10'h104, 1'b0, 5'h0A, 16'h0104);
        @(negedge clk); chk("bp_full_rdy", {31'd0, cmpl_rdy}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        ob_rsp_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("b2b_vld", {31'd0, ob_rsp_vld}, 32'd1);
        end
        @(negedge clk); chk("b2b_end_vld", {31'd0, ob_rsp_vld}, 32'd0);
        chk("b2b_sb_empty", sb.size(), 32'd0);
        @(posedge clk); #1;

        // Pointer wrap with random backpressure.
        fork
            begin
                for (int i = 0; i < 13; i++) begin
                    st  = ((i % 3) == 0);
                    e16 = {st ? 5'(i + 7) : 5'd0, st, 10'(i * 37 + 5)};
                    push(8'(i + 16), 10'(i * 37 + 5), st, 5'(i + 7), e16);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    ob_rsp_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        ob_rsp_rdy = 1'b1;
        drain();
        @(posedge clk); #1;

        // Reset while a response is stalled and two more are queued.
        ob_rsp_rdy = 1'b0;
        push(8'h50, 10'h050, 1'b0, 5'd0, 16'h0050);
        push(8'h51, 10'h051, 1'b0, 5'd0, 16'h0051);
        push(8'h52, 10'h052, 1'b0, 5'd0, 16'h0052);
        @(negedge clk); chk("mid_send_vld", {31'd0, ob_rsp_vld}, 32'd1);
        @(posedge clk); #1;
        rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_vld", {31'd0, ob_rsp_vld}, 32'd0);
        chk("rst_mid_cmpl_rdy", {31'd0, cmpl_rdy}, 32'd1);
        chk("rst_mid_rsp", ob_rsp, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        ob_rsp_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("no_residual_vld", {31'd0, ob_rsp_vld}, 32'd0);
        end
        @(posedge clk); #1;

`ifdef SPU_OBR_ERR_CNT_EN
        err_cnt_clr = 1'b1;
        @(posedge clk); #1;
        err_cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(i + 32), 10'h3FF, 1'b1, 5'h13, 16'h9FFF);
        push(8'd40, 10'h3FF, 1'b0, 5'h13, 16'h03FF);
        drain();
        @(negedge clk); chk("err_cnt_3", {16'd0, err_cnt}, 32'd3);
        @(posedge clk); #1;
        ob_rsp_rdy = 1'b0;
        push(8'd41, 10'h3FF, 1'b1, 5'h13, 16'h9FFF);
        repeat (3) @(negedge clk);
        chk("clr_pre_vld", {31'd0, ob_rsp_vld}, 32'd1);
        @(posedge clk); #1;
        ob_rsp_rdy  = 1'b1;
        err_cnt_clr = 1'b1;
        @(posedge clk); #1;
        err_cnt_clr = 1'b0;
        @(negedge clk); chk("clr_wins", {16'd0, err_cnt}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 65540; i++) push(8'(i), 10'h001, 1'b1, 5'h01, 16'h0C01);
        drain();
        @(negedge clk); chk("err_cnt_sat", {16'd0, err_cnt}, 32'h0000FFFF);
        @(posedge clk); #1;
`endif

        chk("final_sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
